uart_frame_rx: RTL
==================

Name: uart_frame_rx

Overview:
Frame decoder on the receive side of the UART link. It consumes the per-byte strobe stream produced by the UART receiver (valid/data/break) and assembles framed packets of the form SYNC, ADDR, WORD_BYTES data bytes (little-endian), CHK. Each validated (address, word) pair is presented to downstream spiking-network logic on a valid/ready output. It is the decoding end of the host-side frame encoder; framing, checksum and timeout errors are reported as single-cycle pulses.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
WORD_BYTES, 4, data bytes per frame (1..8); output word width = 8*WORD_BYTES
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 100000, max idle clk cycles between bytes inside a frame (>=2)

Ports:
clk  input  1  system clock
resetn  input  1  reset; one clock; reset is asynchronous and active-low
byte_valid  input  1  one-cycle strobe, byte_data valid
byte_data  input  8  received byte
byte_break  input  1  BREAK flag, qualified by byte_valid
frame_valid  output  1  assembled frame available
frame_ready  input  1  downstream accepts frame
frame_addr  output  8  frame address byte
frame_data  output  8*WORD_BYTES  payload; first data byte in [7:0]
err_chk  output  1  one-cycle pulse: checksum mismatch
err_timeout  output  1  one-cycle pulse: inter-byte timeout
err_overflow  output  1  one-cycle pulse: good frame dropped, output still full
busy  output  1  high when FSM is not in HUNT

Behaviour:
- Reset (async assert, sync deassert use): FSM=HUNT; frame_valid=0, frame_addr=0, frame_data=0, all err_*=0, busy=0; byte index, checksum accumulator and timeout counter cleared. Reset mid-frame discards the partial frame and any pending output.
- FSM states: HUNT, ADDR, DATA, CHK.
  - HUNT: on byte_valid && byte_data==SYNC_BYTE go to ADDR, else stay. Non-sync bytes are ignored silently.
  - ADDR: on byte_valid latch the byte into the shadow address, accumulator = byte, idx=0, go to DATA.
  - DATA: on byte_valid store the byte at shadow[8*idx +: 8], accumulator ^= byte, idx++; when idx reaches WORD_BYTES-1 on the strobe, go to CHK.
  - CHK: on byte_valid compare the byte with the accumulator, then go to HUNT.
    - Match with the output register empty, or with frame_valid && frame_ready in the same cycle: copy shadow to frame_addr/frame_data; frame_valid=1 the next cycle (latency 1 clk after the CHK strobe).
    - Match while the output is held (valid && !ready): keep the old output, pulse err_overflow.
    - Mismatch: pulse err_chk, output unchanged.
- A SYNC_BYTE value inside ADDR, DATA or CHK is treated as ordinary data. There is no escaping.
- byte_valid with byte_break=1 in any state: abort to HUNT, no error pulse, byte not used.
- Timeout: the counter runs in ADDR/DATA/CHK, clears on every byte_valid, and clears in HUNT. Reaching TIMEOUT_CYCLES-1 forces HUNT and pulses err_timeout. If a byte_valid arrives in the same cycle, the byte wins and the counter clears.
- Output handshake: frame_valid stays high, with addr/data stable, until a cycle with frame_ready=1, then deasserts the next cycle unless a new frame loads in that same cycle (back-to-back). frame_ready while !frame_valid has no effect.
- err_* are mutually exclusive per cycle and are never asserted during reset.
- Counter width is $clog2(TIMEOUT_CYCLES)+1. idx width is $clog2(WORD_BYTES)+1.

Optional Feature:
UART_FRAME_CRC8_EN
- Defined: the CHK byte is CRC-8, poly 0x07, init 0x00, MSB-first, no reflection, no final XOR, computed over ADDR and all data bytes. One byte is folded per strobe, combinationally.
- Undefined: CHK is the XOR of ADDR and the data bytes. Ports, FSM and latency are identical in both builds.

Decomposition:
- Package uart_frame_pkg:
  - FSM state encoding (HUNT=0, ADDR=1, DATA=2, CHK=3)
  - SYNC default 8'hA5
  - CRC8_POLY 8'h07
  - function chk_step(acc, byte) selecting XOR or CRC-8 under the macro
- Sub-module uart_frame_chk: accumulator register with clear/step controls, output acc. It is shared with the host-side encoder bench model.

Test Plan:
- XOR build, WORD_BYTES=4, bytes A5 03 11 22 33 44 47, frame_ready=1 -> frame_valid for exactly 1 clk one cycle after the 0x47 strobe, frame_addr=0x03, frame_data=0x44332211, no err_*.
- Same frame with CHK=0x48 -> err_chk single pulse, frame_valid stays 0, busy=0 afterwards; a following correct frame is accepted.
- Two good frames with frame_ready=0 throughout -> first frame held stable, err_overflow pulses on the second CHK strobe. Then frame_ready=1 for 1 clk -> frame_valid drops, data is still the first frame.
- TIMEOUT_CYCLES=16, bytes A5 03 11, then silence -> err_timeout pulses 16 clks after the 0x11 strobe, FSM in HUNT. Bytes 22 33 44 47 then produce no frame.
- Garbage 00 FF A5 A5 01 .. -> the second A5 is taken as ADDR=0xA5; the frame completes with CHK computed over A5 01 ...
- resetn pulsed low mid-DATA and during a held frame_valid -> all outputs 0 asynchronously. With UART_FRAME_CRC8_EN, A5 03 11 22 33 44 plus the bench-computed CRC-8 -> frame accepted.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and checksum step for the UART frame decoder.
// Define UART_FRAME_CRC8_EN to switch the frame check byte from XOR to CRC-8.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } frame_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC8_POLY    = 8'h07;

    // Fold one byte into the running check value (CRC-8 is MSB-first, unreflected).
    function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef UART_FRAME_CRC8_EN
        logic [7:0] c;
        c = acc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
`else
        return acc ^ b;
`endif
    endfunction

endpackage

// File: rtl/uart_frame_chk.sv
// Running frame-check accumulator; algorithm chosen by UART_FRAME_CRC8_EN via chk_step.
module uart_frame_chk
    import uart_frame_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       step,
    input  logic [7:0] data_byte,
    output logic [7:0] acc
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (step) begin
            acc <= chk_step(acc, data_byte);
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame decoder: SYNC, ADDR, WORD_BYTES data bytes (LE), CHK -> valid/ready output.
// Check byte is XOR by default, CRC-8 when UART_FRAME_CRC8_EN is defined.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         CLK_HZ         = 50000000,
    parameter int         WORD_BYTES     = 4,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    input  logic                    byte_break,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [7:0]              frame_addr,
    output logic [8*WORD_BYTES-1:0] frame_data,
    output logic                    err_chk,
    output logic                    err_timeout,
    output logic                    err_overflow,
    output logic                    busy
);

    localparam int DW    = 8 * WORD_BYTES;
    localparam int IDX_W = $clog2(WORD_BYTES) + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    generate
        if (WORD_BYTES < 1 || WORD_BYTES > 8 || TIMEOUT_CYCLES < 2 || CLK_HZ < 1) begin : g_bad_params
            $error("uart_frame_rx: parameter out of range");
        end
    endgenerate

    frame_state_t     state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] idle_cnt;
    logic [7:0]       shadow_addr;
    logic [DW-1:0]    shadow_data;
    logic [7:0]       acc;
    logic             acc_clr;
    logic             acc_step;
    logic             timeout_hit;
    logic             out_free;
    logic             chk_match;

    // Accumulator restarts while hunting so ADDR folds into a zero seed.
    assign acc_clr     = (state == ST_HUNT);
    assign acc_step    = byte_valid && !byte_break && (state == ST_ADDR || state == ST_DATA);
    assign timeout_hit = (state != ST_HUNT) && !byte_valid && (idle_cnt == CNT_LAST);
    assign out_free    = !frame_valid || frame_ready;
    assign chk_match   = (byte_data == acc);
    assign busy        = (state != ST_HUNT);

    uart_frame_chk u_chk (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (acc_clr),
        .step      (acc_step),
        .data_byte (byte_data),
        .acc       (acc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_HUNT;
            idx          <= '0;
            idle_cnt     <= '0;
            shadow_addr  <= '0;
            shadow_data  <= '0;
            frame_valid  <= 1'b0;
            frame_addr   <= '0;
            frame_data   <= '0;
            err_chk      <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_chk      <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            if (byte_valid && byte_break) begin
                state    <= ST_HUNT;
                idle_cnt <= '0;
            end else if (timeout_hit) begin
                state       <= ST_HUNT;
                idle_cnt    <= '0;
                err_timeout <= 1'b1;
            end else begin
                if (byte_valid || state == ST_HUNT) begin
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end

                case (state)
                    ST_HUNT: begin
                        if (byte_valid && byte_data == SYNC_BYTE) begin
                            state <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (byte_valid) begin
                            shadow_addr <= byte_data;
                            idx         <= '0;
                            state       <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (byte_valid) begin
                            shadow_data[8*idx +: 8] <= byte_data;
                            idx                     <= idx + 1'b1;
                            if (idx == IDX_LAST) begin
                                state <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (byte_valid) begin
                            state <= ST_HUNT;
                            if (!chk_match) begin
                                err_chk <= 1'b1;
                            end else if (out_free) begin
                                // Overrides the handshake drop above for back-to-back frames.
                                frame_valid <= 1'b1;
                                frame_addr  <= shadow_addr;
                                frame_data  <= shadow_data;
                            end else begin
                                err_overflow <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule
